// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: size defaults,
// write-port priority and a helper to pick one field out of a flattened bus.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int NRD_DEFAULT  = 2;

    // Load writeback (wr1) is younger in program order, so it wins collisions.
    localparam bit WR1_PRIORITY = 1'b1;

    localparam int FIELD_MAX_W = 128;
    localparam int BUS_MAX_W   = 1024;

    // Callers zero-extend the bus to BUS_MAX_W and truncate the result to w bits.
    function automatic logic [FIELD_MAX_W-1:0] bus_field(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [BUS_MAX_W-1:0]   shifted;
        logic [FIELD_MAX_W-1:0] mask;
        shifted = bus >> (k * w);
        if (w >= FIELD_MAX_W) begin
            mask = '1;
        end else begin
            mask = (FIELD_MAX_W'(1) << w) - FIELD_MAX_W'(1);
        end
        return shifted[FIELD_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set by
// issue-stage reservations and cleared by writeback. r0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rsv_en_i,
    input  logic [AW-1:0]   rsv_addr_i,
    input  logic            wr0_en_i,
    input  logic [AW-1:0]   wr0_addr_i,
    input  logic            wr1_en_i,
    input  logic [AW-1:0]   wr1_addr_i,
    output logic [NREG-1:0] busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied before the set so a same-edge reservation of a
    // register being written leaves it busy for the newly issued producer.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en_i && (wr0_addr_i != '0)) begin
            busy_d[wr0_addr_i] = 1'b0;
        end
        if (wr1_en_i && (wr1_addr_i != '0)) begin
            busy_d[wr1_addr_i] = 1'b0;
        end
        if (rsv_en_i && (rsv_addr_i != '0)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD read ports, two write ports, a busy
// scoreboard and a debug port. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = NRD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic [XLEN-1:0]   wr0_data,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [XLEN-1:0]   wr1_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [AW-1:0]     dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:0] busy;

    logic wr0_hit;
    logic wr1_hit;
    logic wr_collide;
    logic wr0_commit;
    logic wr1_commit;

    assign wr0_hit    = wr0_en && (wr0_addr != '0);
    assign wr1_hit    = wr1_en && (wr1_addr != '0);
    assign wr_collide = wr0_hit && wr1_hit && (wr0_addr == wr1_addr);
    assign wr0_commit = wr0_hit && !(wr_collide && WR1_PRIORITY);
    assign wr1_commit = wr1_hit && !(wr_collide && !WR1_PRIORITY);

    always_comb begin
        regs_d = regs_q;
        if (wr0_commit) begin
            regs_d[wr0_addr] = wr0_data;
        end
        if (wr1_commit) begin
            regs_d[wr1_addr] = wr1_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .wr0_en_i   (wr0_en),
        .wr0_addr_i (wr0_addr),
        .wr1_en_i   (wr1_en),
        .wr1_addr_i (wr1_addr),
        .busy_o     (busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stored;

        assign addr   = AW'(bus_field(BUS_MAX_W'(rd_addr), k, AW));
        assign stored = (addr == '0) ? '0 : regs_q[addr];

`ifdef REGFILE_BYPASS_EN
        logic wr0_match;
        logic wr1_match;

        // Commit-qualified matches so a dropped colliding write is never forwarded.
        assign wr0_match = wr0_commit && (wr0_addr == addr);
        assign wr1_match = wr1_commit && (wr1_addr == addr);

        assign rd_data[k*XLEN +: XLEN] = wr1_match ? wr1_data :
                                         wr0_match ? wr0_data : stored;
        assign rd_busy[k] = busy[addr] &
                            ~((wr0_hit && (wr0_addr == addr)) ||
                              (wr1_hit && (wr1_addr == addr)));
`else
        assign rd_data[k*XLEN +: XLEN] = stored;
        assign rd_busy[k]              = busy[addr];
`endif
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: a default-size instance for the
// functional steps and a 16x64, 4-read-port instance for the parameter sweep.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic [1:0]  rdBusy;
    logic        wr0En, wr1En, rsvEn;
    logic [4:0]  wr0Addr, wr1Addr, rsvAddr, dbgAddr;
    logic [31:0] wr0Data, wr1Data, dbgData;

    logic [15:0]  bRdAddr;
    logic [255:0] bRdData;
    logic [3:0]   bRdBusy;
    logic         bWr0En, bWr1En, bRsvEn;
    logic [3:0]   bWr0Addr, bWr1Addr, bRsvAddr, bDbgAddr;
    logic [63:0]  bWr0Data, bWr1Data, bDbgData;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rdAddr),
        .rd_data  (rdData),
        .rd_busy  (rdBusy),
        .wr0_en   (wr0En),
        .wr0_addr (wr0Addr),
        .wr0_data (wr0Data),
        .wr1_en   (wr1En),
        .wr1_addr (wr1Addr),
        .wr1_data (wr1Data),
        .rsv_en   (rsvEn),
        .rsv_addr (rsvAddr),
        .dbg_addr (dbgAddr),
        .dbg_data (dbgData)
    );

    regfile_mp #(
        .XLEN (64),
        .NREG (16),
        .NRD  (4)
    ) dutWide (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (bRdAddr),
        .rd_data  (bRdData),
        .rd_busy  (bRdBusy),
        .wr0_en   (bWr0En),
        .wr0_addr (bWr0Addr),
        .wr0_data (bWr0Data),
        .wr1_en   (bWr1En),
        .wr1_addr (bWr1Addr),
        .wr1_data (bWr1Data),
        .rsv_en   (bRsvEn),
        .rsv_addr (bRsvAddr),
        .dbg_addr (bDbgAddr),
        .dbg_data (bDbgData)
    );

    function automatic logic [31:0] rdA(input int k);
        return rdData[k*32 +: 32];
    endfunction

    // Index pattern stored in the wide instance; r0 is hardwired to zero.
    function automatic logic [63:0] widePattern(input int idx);
        logic [31:0] i32;
        i32 = 32'(idx);
        if (idx == 0) return 64'h0;
        return {i32 ^ 32'hA5A5_0000, i32 * 32'h0101_0101};
    endfunction

    task automatic applyStimulus(
        input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic re,  input logic [4:0] ra
    );
        wr0En = w0e; wr0Addr = w0a; wr0Data = w0d;
        wr1En = w1e; wr1Addr = w1a; wr1Data = w1d;
        rsvEn = re;  rsvAddr = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    initial begin
        int a;
        logic [3:0] addrs [4];

        rst = 1'b0;
        idle();
        rdAddr = '0;
        dbgAddr = '0;
        bRdAddr = '0; bDbgAddr = '0;
        bWr0En = 0; bWr0Addr = '0; bWr0Data = '0;
        bWr1En = 0; bWr1Addr = '0; bWr1Data = '0;
        bRsvEn = 0; bRsvAddr = '0;
        #2;
        checkOutput("reset_rd0",      64'(rdA(0)),  64'h0);
        checkOutput("reset_busy",     64'(rdBusy),  64'h0);
        checkOutput("reset_dbg",      64'(dbgData), 64'h0);
        checkOutput("reset_wide_rd",  64'(bRdData[63:0]), 64'h0);
        checkOutput("reset_wide_busy", 64'(bRdBusy), 64'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        $display("[TB] write r5 with simultaneous reserve");
        rdAddr = {5'd0, 5'd5};
        dbgAddr = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        #1;
        checkOutput("r5_same_cycle", 64'(rdA(0)), BYP ? 64'h1234 : 64'h0);
        checkOutput("r5_busy_before", 64'(rdBusy[0]), 64'h0);
        tick();
        idle();
        #1;
        checkOutput("r5_written", 64'(rdA(0)), 64'h1234);
        checkOutput("r5_busy_after", 64'(rdBusy[0]), 64'h1);
        checkOutput("r5_dbg", 64'(dbgData), 64'h1234);

        $display("[TB] mid-cycle asynchronous reset");
        #1 rst = 1'b0;
        #1;
        checkOutput("async_reset_rd0",  64'(rdA(0)), 64'h0);
        checkOutput("async_reset_busy", 64'(rdBusy[0]), 64'h0);
        checkOutput("async_reset_dbg",  64'(dbgData), 64'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        $display("[TB] r0 write and reserve are ignored");
        rdAddr = {5'd0, 5'd0};
        dbgAddr = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        #1;
        checkOutput("r0_same_cycle", 64'(rdA(0)), 64'h0);
        checkOutput("r0_busy_same",  64'(rdBusy[0]), 64'h0);
        tick();
        idle();
        #1;
        checkOutput("r0_after", 64'(rdA(0)), 64'h0);
        checkOutput("r0_busy_after", 64'(rdBusy[0]), 64'h0);
        checkOutput("r0_dbg", 64'(dbgData), 64'h0);

        $display("[TB] write collision on r7");
        rdAddr = {5'd7, 5'd0};
        dbgAddr = 5'd7;
        applyStimulus(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555, 1'b0, 5'd0);
        #1;
        checkOutput("collide_same_cycle", 64'(rdA(1)), BYP ? 64'h5555 : 64'h0);
        tick();
        idle();
        #1;
        checkOutput("collide_r7", 64'(rdA(1)), 64'h5555);
        checkOutput("collide_dbg", 64'(dbgData), 64'h5555);

        $display("[TB] two writes to different registers");
        applyStimulus(1'b1, 5'd10, 32'hA0A0, 1'b1, 5'd11, 32'hB1B1, 1'b0, 5'd0);
        tick();
        idle();
        rdAddr = {5'd11, 5'd10};
        #1;
        checkOutput("dual_r10", 64'(rdA(0)), 64'hA0A0);
        checkOutput("dual_r11", 64'(rdA(1)), 64'hB1B1);

        $display("[TB] bypass on r3");
        applyStimulus(1'b1, 5'd3, 32'h1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        idle();
        rdAddr = {5'd0, 5'd3};
        #1;
        checkOutput("r3_old", 64'(rdA(0)), 64'h1111);
        applyStimulus(1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("r3_same_cycle", 64'(rdA(0)), BYP ? 64'hDEAD : 64'h1111);
        tick();
        idle();
        #1;
        checkOutput("r3_after", 64'(rdA(0)), 64'hDEAD);

        $display("[TB] scoreboard on r9");
        rdAddr = {5'd9, 5'd0};
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        #1;
        checkOutput("r9_busy_pre", 64'(rdBusy[1]), 64'h0);
        tick();
        idle();
        #1;
        checkOutput("r9_busy_set", 64'(rdBusy[1]), 64'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
        #1;
        checkOutput("r9_busy_masked", 64'(rdBusy[1]), BYP ? 64'h0 : 64'h1);
        checkOutput("r9_data_bypass", 64'(rdA(1)), BYP ? 64'h99 : 64'h0);
        tick();
        idle();
        #1;
        checkOutput("r9_busy_rsv_wins", 64'(rdBusy[1]), 64'h1);
        checkOutput("r9_data", 64'(rdA(1)), 64'h99);
        applyStimulus(1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        #1;
        checkOutput("r9_busy_wr_masked", 64'(rdBusy[1]), BYP ? 64'h0 : 64'h1);
        tick();
        idle();
        #1;
        checkOutput("r9_busy_cleared", 64'(rdBusy[1]), 64'h0);
        checkOutput("r9_data_final", 64'(rdA(1)), 64'h77);

        $display("[TB] wide instance parameter sweep");
        for (int i = 1; i <= 15; i += 2) begin
            bWr0En = 1'b1; bWr0Addr = 4'(i); bWr0Data = widePattern(i);
            bWr1En = (i < 15); bWr1Addr = 4'(i + 1); bWr1Data = widePattern(i + 1);
            tick();
        end
        bWr0En = 1'b0; bWr1En = 1'b0;
        bWr0Addr = '0; bWr1Addr = '0;
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                addrs[0] = 4'd15; addrs[1] = 4'd0; addrs[2] = 4'd1; addrs[3] = 4'd8;
            end else begin
                for (int p = 0; p < 4; p++) addrs[p] = 4'($urandom_range(0, 15));
            end
            for (int p = 0; p < 4; p++) bRdAddr[p*4 +: 4] = addrs[p];
            a = int'($urandom_range(0, 15));
            bDbgAddr = 4'(a);
            #1;
            for (int p = 0; p < 4; p++) begin
                checkOutput($sformatf("wide_r%0d_p%0d", r, p),
                            bRdData[p*64 +: 64], widePattern(int'(addrs[p])));
            end
            checkOutput($sformatf("wide_dbg_r%0d", r), bDbgData, widePattern(a));
            checkOutput($sformatf("wide_busy_r%0d", r), 64'(bRdBusy), 64'h0);
            tick();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core, replacing the fixed 32x32, 2-read/1-write file.
- Configurable width, depth and read-port count, with two write ports (WB0 = ALU/EX writeback, WB1 = load/memory writeback).
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard that produces operand stall flags for the issue stage.
- Debug read port retained for the on-board register viewer.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers including r0. Power of two, at least 2.
- AW, $clog2(NREG), register address width. Derived; do not override.
- NRD, 2, number of read ports, 1 to 4.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. Asserts immediately on falling edge; deasserts synchronously to clk.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k's register has a pending (reserved, not yet written) value.
- wr0_en  in  1  write-port-0 enable.
- wr0_addr  in  AW  write-port-0 address.
- wr0_data  in  XLEN  write-port-0 data.
- wr1_en  in  1  write-port-1 enable.
- wr1_addr  in  AW  write-port-1 address.
- wr1_data  in  XLEN  write-port-1 data.
- rsv_en  in  1  issue stage reserves the destination register.
- rsv_addr  in  AW  register to mark pending.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data; never bypassed.

Behaviour:
- Storage: NREG-1 registers r1..r(NREG-1). r0 is not stored and always reads 0. r0 busy is always 0. Writes and reservations targeting r0 are ignored.
- Reset (rst=0): all registers and all busy bits clear to 0 asynchronously. Consequently rd_data=0, rd_busy=0, dbg_data=0. Reset mid-operation discards any in-flight write or reservation on that edge.
- Writes:
  - Committed on posedge clk when wrN_en=1 and wrN_addr!=0.
  - Different addresses: both commit.
  - Same address, both enabled: wr1 wins (the load result is younger in program order), and wr0 is dropped.
- Reads: combinational, zero latency.
  - Bypass path: if the address matches an enabled nonzero write this cycle, return the write data, with wr1 taking priority over wr0.
  - Otherwise return the stored value.
- Scoreboard, per register, on posedge:
  - set when rsv_en and rsv_addr match;
  - clear when an enabled write (wr0 or wr1) targets it;
  - simultaneous reserve and write to the same register: reserve wins and busy stays 1 (a new producer was issued);
  - otherwise hold.
- rd_busy[k] is combinational: busy[rd_addr[k]] AND NOT (a same-cycle enabled write to that address). If bypass is compiled out, only the first term is used (see Optional Feature).
- Reserving an already-busy register is legal; the bit stays 1. Writing a non-busy register is legal; the bit stays 0.
- No overflow or wrap conditions exist; the address range is covered exactly by NREG.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - same-cycle write data is forwarded to rd_data;
  - a same-cycle write masks rd_busy.
- Undefined:
  - rd_data returns stored contents only, so a write becomes visible the cycle after its edge;
  - rd_busy = busy[addr] unmasked, so the issue stage stalls one extra cycle;
  - saves one comparator and one mux per read port per write port.

Decomposition:
- Shared package regfile_pkg holds:
  - XLEN/NREG defaults;
  - the write-port priority constant (WR1_PRIORITY=1);
  - a helper function that extracts field k of a flattened bus.
- One natural sub-module, regfile_scoreboard: holds the NREG busy bits, takes the rsv and wr interfaces, and outputs the busy vector.
- The read muxes, bypass and storage stay in the top module.

Test Plan:
- Reset: write r5=0x1234, then pulse rst=0 mid-cycle -> rd_data for r5=0 and rd_busy=0 immediately, before the next clk edge.
- r0: wr0 r0=0xFFFFFFFF with rsv r0 -> r0 reads 0, rd_busy=0, dbg_data(r0)=0.
- Write collision: wr0 r7=0xAAAA and wr1 r7=0x5555 on the same edge -> next cycle r7=0x5555. With bypass, the same-cycle read returns 0x5555.
- Bypass: wr0 r3=0xDEAD while rd_addr0=r3 -> with REGFILE_BYPASS_EN, rd_data0=0xDEAD in the same cycle; without it, the old value, then 0xDEAD after the edge.
- Scoreboard: rsv r9 -> next cycle rd_busy=1 for r9. Then wr1 r9 together with rsv r9 on the same edge -> busy stays 1. Then wr0 r9 alone -> busy clears to 0.
- Parameter sweep: NREG=16, XLEN=64, NRD=4 -> write all 15 registers with an index pattern; all four ports read back the correct values at random addresses, and dbg_data matches.
